// File: rtl/systolic_pkg.sv
// Shared types and geometry for the systolic scheduler slice.
// Matrix element (r,c) sits at byte [(r*DIM+c)*ELEM_W +: ELEM_W] of an
// operand and at word [(r*DIM+c)*ACC_W +: ACC_W] of a result.
package systolic_pkg;

    localparam int DIM    = 4;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 32;
    localparam int MAT_W  = DIM * DIM * ELEM_W;  // 128
    localparam int Y_W    = DIM * DIM * ACC_W;   // 512

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_CLEAR
    } sched_state_t;

endpackage

// File: rtl/systolic_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping. The pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan N positions starting at ptr and keep the first hit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/systolic_sched.sv
// Round-robin scheduler sharing one 4x4 systolic core among NUM_REQ
// requesters: accept, issue, wait for done (or time out), respond, then
// hold the core in reset for CLR_CYCLES so it leaves its DONE state.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int TIMEOUT    = 255,
    parameter  int CLR_CYCLES = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MAT_W-1:0] req_a,
    input  logic [NUM_REQ*MAT_W-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [Y_W-1:0]           resp_y,
    output logic                     resp_err,
    output logic                     core_valid_in,
    output logic [MAT_W-1:0]         core_matrix_A,
    output logic [MAT_W-1:0]         core_matrix_B,
    input  logic [Y_W-1:0]           core_y,
    input  logic                     core_done,
    output logic                     core_rst,
    output logic                     busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    sched_state_t     state, state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic             arb_en;
    logic             accept;
    logic [MAT_W-1:0] a_lat, b_lat;
    logic [TMR_W-1:0] timer;
    logic [CLR_W-1:0] clr_cnt;
    logic             job_done, job_timeout, resp_fire, clr_last;
    logic [MAT_W-1:0] a_arr [NUM_REQ];
    logic [MAT_W-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*MAT_W +: MAT_W];
        assign b_arr[i] = req_b[i*MAT_W +: MAT_W];
    end

    // Grants only in IDLE and never while reset is held.
    assign arb_en = (state == S_IDLE) && !reset;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (req_ready),
        .idx   (grant_idx)
    );

    assign accept      = |req_ready;
    assign job_done    = (state == S_WAIT) && core_done;
    // Done wins over timeout when both land in the same cycle.
    assign job_timeout = (state == S_WAIT) && !core_done && (timer == TMR_W'(TIMEOUT - 1));
    assign resp_fire   = (state == S_RESP) && resp_ready;
    assign clr_last    = (clr_cnt == CLR_W'(CLR_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next    = state;
        core_valid_in = 1'b0;
        resp_valid    = 1'b0;
        busy          = (state != S_IDLE);
        core_matrix_A = '0;
        core_matrix_B = '0;
        case (state)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: begin
                core_valid_in = 1'b1;
                state_next    = S_WAIT;
            end
            S_WAIT:  if (job_done || job_timeout) state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_CLEAR;
            end
            S_CLEAR: if (clr_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (state != S_IDLE) begin
            core_matrix_A = a_lat;
            core_matrix_B = b_lat;
        end
    end

    // Operand capture on the grant cycle.
    always_ff @(posedge clk) begin
        // NOTE: operand holding registers carry no reset; they are masked to zero in IDLE.
        if (accept) begin
            a_lat <= a_arr[grant_idx];
            b_lat <= b_arr[grant_idx];
        end
    end

    // Round-robin pointer and response id, updated on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            resp_id <= '0;
        end else if (accept) begin
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            resp_id <= grant_idx;
        end
    end

    // WAIT-state timer: cleared in ISSUE, counts in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 timer <= '0;
        else if (state == S_ISSUE) timer <= '0;
        else if (state == S_WAIT)  timer <= timer + 1'b1;
    end

    // Response payload: core result on done, zero with error on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_y   <= '0;
            resp_err <= 1'b0;
        end else if (job_done) begin
            resp_y   <= core_y;
            resp_err <= 1'b0;
        end else if (job_timeout) begin
            resp_y   <= '0;
            resp_err <= 1'b1;
        end
    end

    // Core reset: asserted through reset and for exactly the CLEAR cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rst <= 1'b1;
            clr_cnt  <= '0;
        end else begin
            core_rst <= (state_next == S_CLEAR);
            if (resp_fire)             clr_cnt <= '0;
            else if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched with a behavioural 4x4 core whose
// done latency is set per job (core_lat < 0 means it never finishes).
module tb_systolic_sched;

    localparam int NREQ = 4;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*128-1:0] req_a, req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [511:0]    resp_y;
    logic            resp_err;
    logic            core_valid_in;
    logic [127:0]    core_matrix_A, core_matrix_B;
    logic [511:0]    core_y = '0;
    logic            core_done = 1'b0;
    logic            core_rst;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int core_lat     = 3;
    int core_cnt     = 0;
    bit core_run     = 1'b0;
    int vin_count    = 0;

    systolic_sched #(.NUM_REQ(NREQ), .TIMEOUT(20), .CLR_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_y        (resp_y),
        .resp_err      (resp_err),
        .core_valid_in (core_valid_in),
        .core_matrix_A (core_matrix_A),
        .core_matrix_B (core_matrix_B),
        .core_y        (core_y),
        .core_done     (core_done),
        .core_rst      (core_rst),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, required $finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [511:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [511:0] y;
        logic [31:0]  acc;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + 32'(a[(r*4+k)*8 +: 8]) * 32'(b[(k*4+c)*8 +: 8]);
                y[(r*4+c)*32 +: 32] = acc;
            end
        return y;
    endfunction

    // Requester id's A is (id+1)*I and B byte k is id*16+k+1, so word k of
    // the product is (id+1)*(id*16+k+1).
    function automatic logic [511:0] exp_y(input int id);
        logic [511:0] y;
        y = '0;
        for (int k = 0; k < 16; k++)
            y[k*32 +: 32] = 32'((id + 1) * (id * 16 + k + 1));
        return y;
    endfunction

    // Behavioural core: done rises core_lat edges after the start pulse.
    always @(posedge clk) begin
        if (core_rst) begin
            core_done <= 1'b0;
            core_y    <= '0;
            core_run  <= 1'b0;
            core_cnt  <= 0;
        end else if (core_valid_in) begin
            core_run <= 1'b1;
            core_cnt <= 1;
        end else if (core_run && !core_done) begin
            if (core_cnt == core_lat) begin
                core_done <= 1'b1;
                core_y    <= matmul(core_matrix_A, core_matrix_B);
            end
            core_cnt <= core_cnt + 1;
        end
    end

    always @(posedge clk) if (core_valid_in) vin_count <= vin_count + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full job: grant, issue, wait, response (optionally held), clear.
    task automatic serve(input int exp_id, input int exp_wait, input bit exp_err, input int hold);
        int           n;
        int           v0;
        int           pulses;
        bit           stable;
        bit           ready_in_clear;
        logic [3:0]   oh;
        logic [511:0] y0;
        logic [1:0]   id0;
        #1;
        oh = 4'b0001 << exp_id;
        n  = 0;
        while (!(|req_ready) && n < 50) begin
            tick();
            n++;
        end
        check("grant", 512'(req_ready), 512'(oh));
        v0 = vin_count;
        tick();
        check("issue_valid", 512'(core_valid_in), 512'(1'b1));
        check("issue_a", 512'(core_matrix_A), 512'(req_a[exp_id*128 +: 128]));
        check("issue_b", 512'(core_matrix_B), 512'(req_b[exp_id*128 +: 128]));
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check("resp_valid", 512'(resp_valid), 512'(1'b1));
        check("wait_cycles", 512'(n - 1), 512'(exp_wait));
        check("resp_id", 512'(resp_id), 512'(exp_id));
        check("resp_err", 512'(resp_err), 512'(exp_err));
        check("resp_y", resp_y, exp_err ? 512'(0) : exp_y(exp_id));
        check("core_rst_in_resp", 512'(core_rst), 512'(1'b0));
        check("busy_in_resp", 512'(busy), 512'(1'b1));
        check("valid_in_once", 512'(vin_count - v0), 512'(1));
        y0     = resp_y;
        id0    = resp_id;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_y !== y0 || resp_id !== id0 || core_rst !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 512'(stable), 512'(1'b1));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_drop", 512'(resp_valid), 512'(1'b0));
        pulses         = 0;
        ready_in_clear = 1'b0;
        while (core_rst === 1'b1 && pulses < 10) begin
            if (|req_ready) ready_in_clear = 1'b1;
            pulses++;
            tick();
        end
        check("clr_cycles", 512'(pulses), 512'(2));
        check("no_ready_in_clear", 512'(ready_in_clear), 512'(1'b0));
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 16; k++) begin
                req_b[i*128 + k*8 +: 8] = 8'(i * 16 + k + 1);
                if (k % 5 == 0) req_a[i*128 + k*8 +: 8] = 8'(i + 1);
            end
        tick();
        tick();

        // Reset state, with requests present to show no grant leaks out.
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", 512'(req_ready), 512'(0));
        check("rst_core_rst", 512'(core_rst), 512'(1'b1));
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_resp_valid", 512'(resp_valid), 512'(1'b0));
        check("rst_valid_in", 512'(core_valid_in), 512'(1'b0));
        check("rst_matrix_a", 512'(core_matrix_A), 512'(0));
        check("rst_resp_y", resp_y, 512'(0));
        check("rst_resp_err", 512'(resp_err), 512'(1'b0));
        req_valid = '0;
        reset     = 1'b0;
        tick();
        check("idle_core_rst", 512'(core_rst), 512'(1'b0));
        check("idle_no_ready", 512'(req_ready), 512'(0));

        // Single job: identity times B returns B; pointer moves to 1.
        req_valid = 4'b0001;
        serve(0, 4, 1'b0, 0);

        // Backpressure: response held 10 cycles.
        req_valid = 4'b0010;
        serve(1, 4, 1'b0, 10);

        // Timeout: core never finishes.
        req_valid = 4'b0100;
        core_lat  = -1;
        serve(2, 20, 1'b1, 0);

        // Done arrives on the same cycle the timer hits TIMEOUT-1.
        req_valid = 4'b1000;
        core_lat  = 19;
        serve(3, 20, 1'b0, 0);

        // Contention from pointer 0: 0,1,2,3 then 1,3.
        req_valid = 4'b1111;
        core_lat  = 3;
        for (int g = 0; g < 4; g++) serve(g, 4, 1'b0, 0);
        req_valid = 4'b1010;
        serve(1, 4, 1'b0, 0);
        serve(3, 4, 1'b0, 0);

        // Reset while in WAIT, then pointer is back at 0.
        req_valid = 4'b0010;
        core_lat  = 30;
        #1;
        n = 0;
        while (!(|req_ready) && n < 50) begin
            tick();
            n++;
        end
        check("midrst_grant", 512'(req_ready), 512'(4'b0010));
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst_core_rst", 512'(core_rst), 512'(1'b1));
        check("midrst_resp_valid", 512'(resp_valid), 512'(1'b0));
        check("midrst_busy", 512'(busy), 512'(1'b0));
        check("midrst_valid_in", 512'(core_valid_in), 512'(1'b0));
        tick();
        reset = 1'b0;
        tick();
        check("postrst_core_rst", 512'(core_rst), 512'(1'b0));
        req_valid = 4'b1111;
        core_lat  = 3;
        serve(0, 4, 1'b0, 0);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
